// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, master IDs and AXI response codes for the memory arbiter.
package mem_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} arb_state_t;
   localparam logic MST_IFU = 1'b0;
   localparam logic MST_LSU = 1'b1;
   localparam logic [1:0] OKAY = 2'b00;
endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner selection between the IFU and LSU request lines.
// req = {lsu_wr, lsu_rd, ifu_rd}; on a tie the master not served last wins, and an LSU write beats an LSU read.
module arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic       last_grant,
   output logic       winner,
   output logic       winner_wr
);
   logic lsu_req;
   assign lsu_req = req[2] | req[1];
   always_comb begin
      winner    = (lsu_req && req[0]) ? (last_grant == MST_IFU ? MST_LSU : MST_IFU) : (lsu_req ? MST_LSU : MST_IFU);
      winner_wr = req[2];
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges IFU reads and LSU reads/writes onto one MMU port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the LSU has fixed priority over the IFU.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   ifu_araddr,
   input  logic [2:0]          ifu_arsize,
   input  logic [7:0]          ifu_arlen,
   input  logic [1:0]          ifu_arburst,
   input  logic                ifu_arvalid,
   output logic                ifu_arready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic [1:0]          ifu_rresp,
   output logic                ifu_rlast,
   output logic                ifu_rvalid,
   input  logic                ifu_rready,
   input  logic [ADDR_W-1:0]   lsu_araddr,
   input  logic [2:0]          lsu_arsize,
   input  logic [7:0]          lsu_arlen,
   input  logic [1:0]          lsu_arburst,
   input  logic                lsu_arvalid,
   output logic                lsu_arready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic [1:0]          lsu_rresp,
   output logic                lsu_rlast,
   output logic                lsu_rvalid,
   input  logic                lsu_rready,
   input  logic [ADDR_W-1:0]   lsu_awaddr,
   input  logic                lsu_awvalid,
   output logic                lsu_awready,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   input  logic                lsu_wvalid,
   output logic                lsu_wready,
   output logic [1:0]          lsu_bresp,
   output logic                lsu_bvalid,
   input  logic                lsu_bready,
   output logic [ADDR_W-1:0]   out_araddr,
   output logic [2:0]          out_arsize,
   output logic [7:0]          out_arlen,
   output logic [1:0]          out_arburst,
   output logic                out_arvalid,
   input  logic                out_arready,
   input  logic [DATA_W-1:0]   out_rdata,
   input  logic [1:0]          out_rresp,
   input  logic                out_rlast,
   input  logic                out_rvalid,
   output logic                out_rready,
   output logic [ADDR_W-1:0]   out_awaddr,
   output logic                out_awvalid,
   input  logic                out_awready,
   output logic [DATA_W-1:0]   out_wdata,
   output logic [DATA_W/8-1:0] out_wstrb,
   output logic                out_wvalid,
   input  logic                out_wready,
   input  logic [1:0]          out_bresp,
   input  logic                out_bvalid,
   output logic                out_bready
);
   arb_state_t state, next_state;
   logic [2:0] req;
   logic last_grant, winner, winner_wr;
   logic g_ifu, g_lrd, g_wr;

   assign req = {lsu_awvalid & lsu_wvalid, lsu_arvalid, ifu_arvalid};

   arb_pick u_pick (
      .req       (req),
      .last_grant(last_grant),
      .winner    (winner),
      .winner_wr (winner_wr)
   );

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) last_grant <= MST_IFU;
      else if (state == IDLE && |req) last_grant <= winner;
`else
   assign last_grant = MST_IFU;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= next_state;

   // Grant decision uses requests only; the done terms are gated to zero while idle.
   always_comb begin
      next_state = state;
      if (state == IDLE && |req)
         next_state = winner == MST_IFU ? IFU_RD : winner_wr ? LSU_WR : LSU_RD;
      else if ((out_bvalid && out_bready) || (out_rvalid && out_rready && out_rlast))
         next_state = IDLE;
   end

   assign g_ifu = state == IFU_RD;
   assign g_lrd = state == LSU_RD;
   assign g_wr  = state == LSU_WR;

   assign out_araddr  = g_ifu ? ifu_araddr  : g_lrd ? lsu_araddr  : '0;
   assign out_arsize  = g_ifu ? ifu_arsize  : g_lrd ? lsu_arsize  : '0;
   assign out_arlen   = g_ifu ? ifu_arlen   : g_lrd ? lsu_arlen   : '0;
   assign out_arburst = g_ifu ? ifu_arburst : g_lrd ? lsu_arburst : '0;
   assign out_arvalid = (g_ifu & ifu_arvalid) | (g_lrd & lsu_arvalid);
   assign out_rready  = (g_ifu & ifu_rready)  | (g_lrd & lsu_rready);

   assign ifu_arready = g_ifu & out_arready;
   assign ifu_rvalid  = g_ifu & out_rvalid;
   assign ifu_rdata   = g_ifu ? out_rdata : '0;
   assign ifu_rresp   = g_ifu ? out_rresp : OKAY;
   assign ifu_rlast   = g_ifu & out_rlast;

   assign lsu_arready = g_lrd & out_arready;
   assign lsu_rvalid  = g_lrd & out_rvalid;
   assign lsu_rdata   = g_lrd ? out_rdata : '0;
   assign lsu_rresp   = g_lrd ? out_rresp : OKAY;
   assign lsu_rlast   = g_lrd & out_rlast;

   assign out_awaddr  = g_wr ? lsu_awaddr : '0;
   assign out_awvalid = g_wr & lsu_awvalid;
   assign lsu_awready = g_wr & out_awready;
   assign out_wdata   = g_wr ? lsu_wdata : '0;
   assign out_wstrb   = g_wr ? lsu_wstrb : '0;
   assign out_wvalid  = g_wr & lsu_wvalid;
   assign lsu_wready  = g_wr & out_wready;
   assign out_bready  = g_wr & lsu_bready;
   assign lsu_bvalid  = g_wr & out_bvalid;
   assign lsu_bresp   = g_wr ? out_bresp : OKAY;

`ifndef SYNTHESIS
   logic granted_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) granted_q <= 1'b0;
      else begin
         granted_q <= state == IDLE && next_state != IDLE;
         if (granted_q && !out_arvalid && !(out_awvalid && out_wvalid))
            $error("mem_arbiter: granted master dropped its request valid");
      end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and randomized traffic checked against a transaction-level model.
module tb_mem_arbiter;
   localparam int K_IFU = 0, K_LRD = 1, K_LWR = 2;
`ifdef ARB_ROUND_ROBIN_EN
   localparam int BOTH = K_IFU;
`else
   localparam int BOTH = K_LWR;
`endif

   logic clk = 1'b0, rst = 1'b1;
   logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, out_araddr, out_awaddr;
   logic [2:0]  ifu_arsize, lsu_arsize, out_arsize;
   logic [7:0]  ifu_arlen, lsu_arlen, out_arlen;
   logic [1:0]  ifu_arburst, lsu_arburst, out_arburst;
   logic        ifu_arvalid, ifu_arready, lsu_arvalid, lsu_arready, out_arvalid, out_arready;
   logic [31:0] ifu_rdata, lsu_rdata, out_rdata, lsu_wdata, out_wdata;
   logic [1:0]  ifu_rresp, lsu_rresp, out_rresp, lsu_bresp, out_bresp;
   logic        ifu_rlast, lsu_rlast, out_rlast;
   logic        ifu_rvalid, ifu_rready, lsu_rvalid, lsu_rready, out_rvalid, out_rready;
   logic        lsu_awvalid, lsu_awready, out_awvalid, out_awready;
   logic [3:0]  lsu_wstrb, out_wstrb;
   logic        lsu_wvalid, lsu_wready, out_wvalid, out_wready;
   logic        lsu_bvalid, lsu_bready, out_bvalid, out_bready;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_arlen(ifu_arlen), .ifu_arburst(ifu_arburst),
      .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
      .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
      .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arlen(lsu_arlen), .lsu_arburst(lsu_arburst),
      .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
      .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
      .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
      .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
      .out_araddr(out_araddr), .out_arsize(out_arsize), .out_arlen(out_arlen), .out_arburst(out_arburst),
      .out_arvalid(out_arvalid), .out_arready(out_arready),
      .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast), .out_rvalid(out_rvalid), .out_rready(out_rready),
      .out_awaddr(out_awaddr), .out_awvalid(out_awvalid), .out_awready(out_awready),
      .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wvalid(out_wvalid), .out_wready(out_wready),
      .out_bresp(out_bresp), .out_bvalid(out_bvalid), .out_bready(out_bready)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   bit ifu_p, lrd_p, lwr_p;
   int last_srv;

   typedef struct { bit ifu; bit lrd; bit lwr; int exp; } vec_t;
   vec_t tbl[6];
   int exp3[3];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_check(input string name);
      #1;
      check(name, {out_arvalid, out_awvalid, out_wvalid, out_rready, out_bready,
                   ifu_arready, lsu_arready, lsu_awready, lsu_wready}, '0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid} = '0;
      {out_rvalid, out_bvalid, out_arready, out_awready, out_wready} = '0;
      {ifu_rready, lsu_rready, lsu_bready, out_rlast} = '0;
      ifu_p = 0; lrd_p = 0; lwr_p = 0; last_srv = K_IFU;
      #2 rst = 1'b0;
      tick();
   endtask

   task automatic raise(input int k, input logic [31:0] addr, input logic [7:0] len);
      if (k == K_IFU) begin
         ifu_p = 1; ifu_araddr = addr; ifu_arlen = len;
         ifu_arsize = 3'($urandom_range(0, 2)); ifu_arburst = 2'($urandom); ifu_arvalid = 1'b1;
      end else if (k == K_LRD) begin
         lrd_p = 1; lsu_araddr = addr; lsu_arlen = len;
         lsu_arsize = 3'($urandom_range(0, 2)); lsu_arburst = 2'($urandom); lsu_arvalid = 1'b1;
      end else begin
         lwr_p = 1; lsu_awaddr = addr; lsu_wdata = $urandom; lsu_wstrb = 4'($urandom);
         lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
      end
   endtask

   // Transaction-level rule: LSU wins unless round-robin hands a tie to the master not served last.
   function automatic int predict();
      bit lsu, pick_lsu;
      lsu = lrd_p || lwr_p;
`ifdef ARB_ROUND_ROBIN_EN
      pick_lsu = lsu && (!ifu_p || last_srv == K_IFU);
`else
      pick_lsu = lsu;
`endif
      return !pick_lsu ? K_IFU : lwr_p ? K_LWR : K_LRD;
   endfunction

   // Called in the first grant cycle; plays the MMU and the granted master until the final response.
   task automatic serve(input int k, input int inj, input logic [31:0] d0);
      int lat;
      bit gi;
      logic [7:0] len;
      logic [31:0] rd;
      logic [1:0] rs;
      lat = $urandom_range(0, 2);
      if (k == K_LWR) begin
         check("aw_grant", {out_awvalid, out_wvalid, out_arvalid}, 3'b110);
         check("aw_payload", {out_awaddr, out_wstrb}, {lsu_awaddr, lsu_wstrb});
         check("w_data", out_wdata, lsu_wdata);
         out_awready = 1'b1; out_wready = 1'b1; #1;
         check("aw_ready", {lsu_awready, lsu_wready, lsu_arready, ifu_arready}, 4'b1100);
         tick();
         out_awready = 1'b0; out_wready = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; lwr_p = 0;
         repeat (lat) tick();
         if ($urandom_range(0, 1) == 1) begin
            out_bvalid = 1'b1; out_bresp = 2'b10; lsu_bready = 1'b0; #1;
            check("b_stall", {lsu_bvalid, out_bready, ifu_rvalid}, 3'b100);
            tick();
         end
         rs = 2'($urandom);
         out_bvalid = 1'b1; out_bresp = rs; lsu_bready = 1'b1; #1;
         check("b_resp", {lsu_bvalid, out_bready, lsu_bresp, ifu_rvalid, lsu_rvalid}, {2'b11, rs, 2'b00});
         tick();
         out_bvalid = 1'b0; lsu_bready = 1'b0; last_srv = K_LRD;
      end else begin
         gi = k == K_IFU;
         len = gi ? ifu_arlen : lsu_arlen;
         check("ar_grant", {out_arvalid, out_awvalid}, 2'b10);
         check("ar_payload", {out_araddr, out_arsize, out_arlen, out_arburst},
               gi ? {ifu_araddr, ifu_arsize, ifu_arlen, ifu_arburst} : {lsu_araddr, lsu_arsize, lsu_arlen, lsu_arburst});
         out_arready = 1'b1; #1;
         check("ar_ready", {ifu_arready, lsu_arready, lsu_awready}, {gi, !gi, 1'b0});
         tick();
         out_arready = 1'b0;
         if (gi) begin ifu_arvalid = 1'b0; ifu_p = 0; end
         else begin lsu_arvalid = 1'b0; lrd_p = 0; end
         repeat (lat) tick();
         for (int b = 0; b <= int'(len); b++) begin
            if (b == inj) raise(K_LWR, 32'h8000_0200, 8'd0);
            if ($urandom_range(0, 3) == 0) begin
               out_rvalid = 1'b1; out_rlast = b == int'(len); out_rdata = $urandom;
               ifu_rready = 1'b0; lsu_rready = 1'b0; #1;
               check("r_stall", {ifu_rvalid, lsu_rvalid, out_rready}, {gi, !gi, 1'b0});
               tick();
            end
            rd = (b == 0 && d0 != 0) ? d0 : $urandom;
            rs = 2'($urandom);
            out_rvalid = 1'b1; out_rdata = rd; out_rresp = rs; out_rlast = b == int'(len);
            ifu_rready = 1'b1; lsu_rready = 1'b1; #1;
            check("r_beat", gi ? {ifu_rvalid, ifu_rdata, ifu_rresp, ifu_rlast} : {lsu_rvalid, lsu_rdata, lsu_rresp, lsu_rlast},
                  {1'b1, rd, rs, b == int'(len)});
            check("r_other", gi ? {lsu_rvalid, lsu_rdata, lsu_rlast, out_awvalid} : {ifu_rvalid, ifu_rdata, ifu_rlast, out_awvalid}, '0);
            check("r_rready", out_rready, 1);
            tick();
            out_rvalid = 1'b0; out_rlast = 1'b0; ifu_rready = 1'b0; lsu_rready = 1'b0;
         end
         last_srv = gi ? K_IFU : K_LRD;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && (ifu_p || lrd_p || lwr_p); i++) begin
         int k;
         idle_check("idle_gap");
         k = predict();
         tick();
         serve(k, -1, 32'd0);
      end
   endtask

   initial begin
      {ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata} = '0;
      {ifu_arsize, lsu_arsize, ifu_arlen, lsu_arlen, ifu_arburst, lsu_arburst, lsu_wstrb} = '0;
      {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid, out_rresp, out_bresp} = '0;
      out_rvalid = 1'b1; out_bvalid = 1'b1; out_arready = 1'b1; out_awready = 1'b1; out_wready = 1'b1;
      out_rlast = 1'b1; out_rdata = '1; ifu_rready = 1'b1; lsu_rready = 1'b1; lsu_bready = 1'b1;
      lsu_awaddr = 32'hFFFF_FFFF; ifu_araddr = 32'hFFFF_FFFF;
      #12;
      check("rst_handshake", {ifu_rvalid, lsu_rvalid, lsu_bvalid, out_arvalid, out_awvalid, out_wvalid,
                              out_rready, out_bready, ifu_arready, lsu_arready, lsu_awready, lsu_wready}, '0);
      check("rst_rdata", {ifu_rdata, lsu_rdata}, '0);
      check("rst_addr", {out_araddr, out_awaddr}, '0);
      check("rst_misc", {out_wdata, out_wstrb, ifu_rlast, lsu_rlast, out_arlen}, '0);
      do_reset();

      raise(K_IFU, 32'h8000_0000, 8'd0);
      ifu_arsize = 3'd2; ifu_arburst = 2'b01; #1;
      check("req_idle", out_arvalid, 0);
      tick();
      check("plan_araddr", {out_arvalid, out_araddr}, {1'b1, 32'h8000_0000});
      serve(K_IFU, -1, 32'hDEAD_BEEF);
      raise(K_IFU, 32'h8000_0040, 8'd0);
      idle_check("ifu_idle");
      tick();
      serve(K_IFU, -1, 32'd0);

      raise(K_LWR, 32'h8000_0100, 8'd0);
      lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hF;
      idle_check("wr_req");
      tick();
      check("plan_aw", {out_awaddr, out_wdata, out_wstrb}, {32'h8000_0100, 32'h1234_5678, 4'hF});
      serve(K_LWR, -1, 32'd0);
      idle_check("wr_idle");

`ifdef ARB_ROUND_ROBIN_EN
      exp3 = '{K_LRD, K_IFU, K_LRD};
`else
      exp3 = '{K_LRD, K_LRD, K_LRD};
`endif
      do_reset();
      raise(K_IFU, $urandom, 8'd1);
      raise(K_LRD, $urandom, 8'd1);
      for (int r = 0; r < 3; r++) begin
         idle_check("rr_idle");
         tick();
         serve(exp3[r], -1, 32'd0);
         raise(exp3[r] == K_IFU ? K_IFU : K_LRD, $urandom, 8'd0);
      end
      drain();

      raise(K_IFU, 32'h8000_1000, 8'd3);
      idle_check("burst_req");
      tick();
      serve(K_IFU, 2, 32'd0);
      check("burst_lsu_waiting", {lsu_awvalid, out_awvalid}, 2'b10);
      drain();

      raise(K_LWR, 32'h8000_0300, 8'd0);
      idle_check("rst_wr_req");
      tick();
      check("rst_wr_grant", out_awvalid, 1);
      out_awready = 1'b1; out_wready = 1'b1;
      tick();
      out_awready = 1'b0; out_wready = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
      out_bvalid = 1'b1; #1;
      check("pre_rst_bvalid", {lsu_bvalid, out_bready}, 2'b10);
      rst = 1'b1; #1;
      check("rst_mid_wr", {lsu_bvalid, out_bready, out_awvalid, out_wvalid, lsu_awready, lsu_wready, out_arvalid}, '0);
      check("rst_mid_payload", {out_awaddr, out_wstrb}, '0);
      out_bvalid = 1'b0;
      do_reset();
      raise(K_IFU, 32'h8000_2000, 8'd0);
      idle_check("post_rst_req");
      tick();
      serve(K_IFU, -1, 32'd0);

      do_reset();
      tbl[0] = '{ifu: 1, lrd: 0, lwr: 0, exp: K_IFU};
      tbl[1] = '{ifu: 0, lrd: 1, lwr: 0, exp: K_LRD};
      tbl[2] = '{ifu: 0, lrd: 0, lwr: 1, exp: K_LWR};
      tbl[3] = '{ifu: 0, lrd: 1, lwr: 1, exp: K_LWR};
      tbl[4] = '{ifu: 1, lrd: 0, lwr: 1, exp: BOTH};
      tbl[5] = '{ifu: 1, lrd: 1, lwr: 1, exp: BOTH};
      foreach (tbl[i]) begin
         if (tbl[i].ifu) raise(K_IFU, $urandom, 8'($urandom_range(0, 2)));
         if (tbl[i].lrd) raise(K_LRD, $urandom, 8'($urandom_range(0, 2)));
         if (tbl[i].lwr) raise(K_LWR, $urandom, 8'd0);
         idle_check("tbl_idle");
         tick();
         serve(tbl[i].exp, -1, 32'd0);
         drain();
      end

      for (int t = 0; t < 40; t++) begin
         int m;
         m = $urandom_range(1, 7);
         if (m[0]) raise(K_IFU, $urandom, 8'($urandom_range(0, 3)));
         if (m[1]) raise(K_LRD, $urandom, 8'($urandom_range(0, 3)));
         if (m[2]) raise(K_LWR, $urandom, 8'd0);
         drain();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
